uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 37 +++
 rtl/uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver/FIFO (master) and its byte consumer (slave).
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               rx;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [COUNT_W-1:0] fifo_count;
    logic               framing_err;
    logic               overrun_err;
    logic               parity_err;

    modport master (
        input  rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output fifo_count,
        output framing_err,
        output overrun_err,
        output parity_err
    );

    modport slave (
        output rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  fifo_count,
        input  framing_err,
        input  overrun_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 234,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.master bus
);
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = ADDR_W + 1;
    localparam logic [15:0]        BIT_TICKS  = 16'(BAUD_DIV);
    localparam logic [15:0]        HALF_TICKS = 16'(BAUD_DIV / 2);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    logic               rx_meta;
    logic               rx_sync;
    logic               rx_prev;
    state_t             state;
    logic [15:0]        cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               framing_err;
    logic               overrun_err;
    logic               parity_err;
    logic               expired;
    logic               frame_ok;
    logic               push_now;
    logic               do_pop;
    logic               do_push;
    logic               full;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [COUNT_W-1:0] count;
`ifdef UART_RX_PARITY_EN
    logic               parity_bit;
`endif

    // rx_prev lets IDLE see a 1->0 step using only synchronized samples
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign expired = (cnt <= 16'd1);

`ifdef UART_RX_PARITY_EN
    assign frame_ok = rx_sync && !(^{shreg, parity_bit});
`else
    assign frame_ok = rx_sync;
`endif

    assign push_now = (state == STOP) && expired && frame_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit  <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                        cnt   <= HALF_TICKS;
                    end
                end
                START: begin
                    if (expired) begin
                        if (!rx_sync) begin
                            state   <= DATA;
                            cnt     <= BIT_TICKS;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= BIT_TICKS;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (expired) begin
                        parity_bit <= rx_sync;
                        cnt        <= BIT_TICKS;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (expired) begin
`ifdef UART_RX_PARITY_EN
                        parity_err <= ^{shreg, parity_bit};
`endif
                        if (rx_sync) begin
                            state <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign full    = (count == FULL_COUNT);
    assign do_pop  = (count != '0) && bus.rx_ready;
    assign do_push = push_now && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= push_now && full && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.rx_valid    = (count != '0);
    assign bus.rx_data     = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.fifo_count  = count;
    assign bus.framing_err = framing_err;
    assign bus.overrun_err = overrun_err;
    assign bus.parity_err  = parity_err;
endmodule
